divu_iter: RTL and testbench

- Iterative unsigned integer divider, the inverse companion of the sequential unsigned multiplier in the arithmetic unit.
- Produces one quotient bit per clock using a restoring shift/subtract algorithm.
- Has a start/busy/done handshake so the CPU datapath can issue DIVU and stall until the result is ready.
- Sits beside the multiplier; the HI/LO write-back logic takes r and q.

---
 rtl/divu_pkg.sv | 14 +
 rtl/divu_iter_if.sv | 23 ++
 rtl/divu_step.sv | 18 +
 rtl/divu_iter.sv | 100 ++++++++++
 tb/tb_divu_iter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/divu_pkg.sv
// Shared constants and FSM encoding for the iterative unsigned divider.
package divu_pkg;

    localparam int DIVU_WIDTH = 32;

    typedef logic [1:0] divu_state_t;

    localparam divu_state_t IDLE = 2'd0;
    localparam divu_state_t RUN  = 2'd1;
    localparam divu_state_t DONE = 2'd2;

    localparam logic [DIVU_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divu_iter_if.sv
// Request/result bundle between the datapath issue logic and the divider.
interface divu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  q, r, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output q, r, busy, done, div_by_zero
    );
endinterface

// File: rtl/divu_step.sv
// One restoring shift/subtract iteration; purely combinational.
// Latency 0; no handshake.
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0] w_trial;

    // Full-width remainder plus one extra bit keeps MSB-set divisors exact.
    assign w_trial = {i_rem, i_msb};
    assign o_qbit  = (w_trial >= {1'b0, i_divisor});
    assign o_rem   = w_trial[WIDTH-1:0] - (o_qbit ? i_divisor : '0);
endmodule

// File: rtl/divu_iter.sv
// Iterative unsigned divider, one quotient bit per clock (restoring).
// Latency WIDTH clocks accept-to-done (0 for divide by zero); start ignored while busy.
module divu_iter
    import divu_pkg::*;
#(
    parameter  int WIDTH = DIVU_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      reset,
    divu_iter_if.slave bus
);
    divu_state_t      r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;
    logic             w_accept;
    logic             w_last;

    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    divu_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_msb     (r_shift[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept && (bus.divisor == '0)) begin
                        r_q     <= '1;
                        r_r     <= bus.dividend;
                        r_dbz   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_accept) begin
                        r_div   <= bus.divisor;
                        r_rem   <= '0;
                        r_shift <= bus.dividend;
                        r_cnt   <= '0;
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Quotient bits fill the shift register as the dividend leaves it.
                    r_rem   <= w_rem_next;
                    r_shift <= {r_shift[WIDTH-2:0], w_qbit};
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_q     <= {r_shift[WIDTH-2:0], w_qbit};
                        r_r     <= w_rem_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.q           = r_q;
    assign bus.r           = r_r;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divu_iter.sv
// Scoreboard bench for divu_iter: directed corner cases then random operand pairs.
module tb_divu_iter;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic [7:0]   lat;
        logic [7:0]   busy_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    divu_iter_if #(.WIDTH(W)) bus ();

    divu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request, push the reference result, return #1 after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.q        = (b == '0) ? '1 : a / b;
        e.r        = (b == '0) ? a : a % b;
        e.dbz      = (b == '0);
        e.lat      = (b == '0) ? 8'd0 : 8'd32;
        e.busy_cyc = (b == '0) ? 8'd0 : 8'd32;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // Wait for done (bounded), optionally firing a stray start at edge count inj.
    task automatic wait_done(input int inj);
        int   n;
        int   bcnt;
        logic ovl;
        exp_t e;
        n    = 0;
        bcnt = int'(bus.busy);
        ovl  = bus.busy & bus.done;
        while (!bus.done && n < 200) begin
            if (n == inj) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd20;
                bus.divisor  = 32'd20;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
            bcnt += int'(bus.busy);
            ovl  |= bus.busy & bus.done;
        end
        check_val("done_seen", 64'(bus.done), 64'd1);
        check_val("busy_done_overlap", 64'(ovl), 64'd0);
        if (sb.size() == 0) begin
            check_val("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check_val("q", 64'(bus.q), 64'(e.q));
            check_val("r", 64'(bus.r), 64'(e.r));
            check_val("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            check_val("latency", 64'(n), 64'(e.lat));
            check_val("busy_cycles", 64'(bcnt), 64'(e.busy_cyc));
        end
    endtask

    initial begin
        logic seen;
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_q", 64'(bus.q), 64'd0);
        check_val("rst_r", 64'(bus.r), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        start_op(32'd100, 32'd7);
        check_val("busy_after_accept", 64'(bus.busy), 64'd1);
        wait_done(-1);
        @(posedge clk);
        #1;
        check_val("done_one_cycle", 64'(bus.done), 64'd0);
        check_val("q_hold", 64'(bus.q), 64'd14);
        check_val("r_hold", 64'(bus.r), 64'd2);

        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(-1);
        start_op(32'hFFFF_FFFF, 32'h8000_0000);
        wait_done(-1);
        @(negedge clk);
        start_op(32'd3, 32'd10);
        wait_done(-1);
        @(negedge clk);
        start_op(32'd5, 32'd0);
        check_val("dbz_busy_low", 64'(bus.busy), 64'd0);
        wait_done(-1);
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        start_op(32'd50, 32'd50);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_val("arst_q", 64'(bus.q), 64'd0);
        check_val("arst_r", 64'(bus.r), 64'd0);
        check_val("arst_busy", 64'(bus.busy), 64'd0);
        check_val("arst_done", 64'(bus.done), 64'd0);
        check_val("arst_dbz", 64'(bus.div_by_zero), 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.done | bus.busy;
        end
        check_val("idle_after_rst", 64'(seen), 64'd0);
        start_op(32'd50, 32'd50);
        wait_done(-1);
        @(negedge clk);

        // Stray start mid-run, then back-to-back accept out of DONE.
        start_op(32'd1000, 32'd10);
        wait_done(9);
        start_op(32'd20, 32'd20);
        wait_done(-1);
        @(negedge clk);

        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = $urandom | 32'h8000_0000;
                3:       b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            start_op(a, b);
            wait_done(-1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
